// File: rtl/seq_chk_if.sv
// seq_chk_if: sample stream from the sequence generator plus checker status back to the monitor side.
interface seq_chk_if #(parameter int CNT_W = 8);
  logic [2:0] dato_in;
  logic valid;
  logic clr_err;
  logic locked;
  logic error;
  logic [CNT_W-1:0] err_count;
  logic [1:0] estado_salida;
  modport master (output dato_in, valid, clr_err, input locked, error, err_count, estado_salida);
  modport slave (input dato_in, valid, clr_err, output locked, error, err_count, estado_salida);
endinterface

// File: rtl/fsm_seq_checker.sv
// fsm_seq_checker: lock/loss monitor for the 0..7 counting sequence with saturating error count.
// Optional macro SEQ_CHK_RESYNC_EN: on a locked mismatch realign the prediction to the received value.
module fsm_seq_checker #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  seq_chk_if.slave bus
);
  typedef enum logic [1:0] {HUNT = 2'b00, SYNC = 2'b01, LOCK = 2'b10, BAD = 2'b11} state_t;
  state_t state, state_nx;
  logic [2:0] exp_q, exp_nx, dato_nx;
  logic [3:0] run, run_nx, run_inc;
  logic error, error_nx, inc, match;
  logic [CNT_W-1:0] cnt, cnt_nx;
  always_comb begin
    state_nx = state;
    exp_nx = exp_q;
    run_nx = run;
    error_nx = 1'b0;
    inc = 1'b0;
    match = bus.dato_in == exp_q;
    run_inc = run + 4'd1;
    dato_nx = bus.dato_in + 3'd1;
    if (state == BAD) begin
      state_nx = HUNT;
      run_nx = '0;
    end else if (bus.valid) begin
      case (state)
        HUNT: begin
          exp_nx = dato_nx;
          run_nx = '0;
          state_nx = SYNC;
        end
        SYNC: begin
          exp_nx = dato_nx;
          run_nx = (match && run_inc != 4'(LOCK_N)) ? run_inc : 4'd0;
          state_nx = (match && run_inc == 4'(LOCK_N)) ? LOCK : SYNC;
        end
        default: begin
          if (match) begin
            exp_nx = exp_q + 3'd1;
            run_nx = '0;
          end else begin
            error_nx = 1'b1;
            inc = 1'b1;
`ifdef SEQ_CHK_RESYNC_EN
            exp_nx = dato_nx;
`else
            exp_nx = exp_q + 3'd1;
`endif
            run_nx = (run_inc == 4'(LOSS_N)) ? 4'd0 : run_inc;
            state_nx = (run_inc == 4'(LOSS_N)) ? HUNT : LOCK;
          end
        end
      endcase
    end
    // clear has priority over a same-cycle increment
    cnt_nx = bus.clr_err ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      exp_q <= '0;
      run <= '0;
      error <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      exp_q <= exp_nx;
      run <= run_nx;
      error <= error_nx;
      cnt <= cnt_nx;
    end
  end
  assign bus.locked = state == LOCK;
  assign bus.error = error;
  assign bus.err_count = cnt;
  assign bus.estado_salida = state;
endmodule

// File: tb/tb_fsm_seq_checker.sv
// tb_fsm_seq_checker: directed checks of lock, wrap, glitch, saturation, clear and async reset.
module tb_fsm_seq_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] e, w, nxt;
  seq_chk_if #(.CNT_W(8)) bus1 ();
  seq_chk_if #(.CNT_W(2)) bus2 ();
  fsm_seq_checker #(.LOCK_N(4), .LOSS_N(3), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fsm_seq_checker #(.LOCK_N(4), .LOSS_N(3), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic vl, input logic clr);
    bus1.dato_in = v; bus1.valid = vl; bus1.clr_err = clr;
    bus2.dato_in = v; bus2.valid = vl; bus2.clr_err = clr;
  endtask

  task automatic send(input logic [2:0] v, input logic clr);
    @(negedge clk);
    drive(v, 1'b1, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_locked", bus1.locked, 0);
    chk("rst_error", bus1.error, 0);
    chk("rst_cnt", bus1.err_count, 0);
    chk("rst_cnt2", bus2.err_count, 0);
    chk("rst_state", bus1.estado_salida, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic isolated_mismatch(input logic clr, input int k_cnt1, input int k_cnt2);
    w = e + 3'd4;
    send(w, clr);
    chk("iso_error", bus1.error, 1);
    chk("iso_locked", bus1.locked, 1);
    chk("iso_cnt", bus1.err_count, k_cnt1);
    chk("iso_cnt_sat", bus2.err_count, k_cnt2);
`ifdef SEQ_CHK_RESYNC_EN
    nxt = w + 3'd1;
`else
    nxt = e + 3'd1;
`endif
    send(nxt, 1'b0);
    chk("iso_recover_error", bus1.error, 0);
    e = nxt + 3'd1;
  endtask

  initial begin
    drive(3'd0, 1'b0, 1'b0);
    #12;
    chk("reset_locked", bus1.locked, 0);
    chk("reset_error", bus1.error, 0);
    chk("reset_cnt", bus1.err_count, 0);
    chk("reset_state", bus1.estado_salida, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd0, 1'b0);
    chk("seed_state", bus1.estado_salida, 1);
    for (int i = 1; i <= 3; i++) send(3'(i), 1'b0);
    chk("pre_lock_locked", bus1.locked, 0);
    chk("pre_lock_state", bus1.estado_salida, 1);
    send(3'd4, 1'b0);
    chk("lock_locked", bus1.locked, 1);
    chk("lock_state", bus1.estado_salida, 2);
    chk("lock_cnt", bus1.err_count, 0);
    for (int i = 5; i <= 12; i++) begin
      send(3'(i), 1'b0);
      chk("wrap_error", bus1.error, 0);
      chk("wrap_locked", bus1.locked, 1);
    end
    send(3'd5, 1'b0);
    send(3'd6, 1'b0);
    chk("glitch_pre_error", bus1.error, 0);
    send(3'd3, 1'b0);
    chk("glitch3_error", bus1.error, 1);
    chk("glitch3_locked", bus1.locked, 1);
    send(3'd4, 1'b0);
`ifdef SEQ_CHK_RESYNC_EN
    chk("glitch4_error", bus1.error, 0);
    send(3'd5, 1'b0);
    chk("glitch5_error", bus1.error, 0);
    chk("glitch5_locked", bus1.locked, 1);
    chk("glitch_cnt", bus1.err_count, 1);
`else
    chk("glitch4_error", bus1.error, 1);
    chk("glitch4_locked", bus1.locked, 1);
    send(3'd5, 1'b0);
    chk("glitch5_error", bus1.error, 1);
    chk("glitch5_locked", bus1.locked, 0);
    chk("glitch5_state", bus1.estado_salida, 0);
    chk("glitch_cnt", bus1.err_count, 3);
`endif
    pulse_reset();
    for (int i = 0; i <= 4; i++) send(3'(i), 1'b0);
    chk("relock_locked", bus1.locked, 1);
    e = 3'd5;
    for (int k = 1; k <= 5; k++) isolated_mismatch(1'b0, k, (k > 3) ? 3 : k);
    chk("sat_cnt2", bus2.err_count, 3);
    chk("sat_cnt1", bus1.err_count, 5);
    isolated_mismatch(1'b1, 0, 0);
    isolated_mismatch(1'b0, 1, 1);
    isolated_mismatch(1'b0, 2, 2);
    @(negedge clk);
    drive(e + 3'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("gap_error", bus1.error, 0);
    chk("gap_state", bus1.estado_salida, 2);
    chk("gap_cnt", bus1.err_count, 2);
    send(e, 1'b0);
    chk("after_gap_error", bus1.error, 0);
    pulse_reset();
    send(3'd3, 1'b0);
    chk("post_reset_state", bus1.estado_salida, 1);
    chk("post_reset_locked", bus1.locked, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
